lfsr_16_checker: RTL
====================

Name: lfsr_16_checker

Overview:
- Receive-side companion to the team's 16-bit Galois LFSR pattern generator.
- Each valid cycle, takes one full 16-bit generator state word. It self-seeds from the stream and predicts every following word with the same step function. It declares lock, then flags and counts mismatches.
- Used as a link/BIST checker on the audio data path: the generator drives data_in at the far end of the link.

Parameters:
- LOCK_COUNT, 4: consecutive correct predictions needed to assert locked_out (legal 1..255).
- ERR_THRESH, 3: consecutive mismatches in LOCKED that force a resync (legal 1..255).
- CNT_W, 16: width of err_count_out and word_count_out.

Ports:
- clk_in  input  1  system clock; all logic on rising edge
- rst_in  input  1  synchronous, active-high reset
- data_in  input  16  received generator state word
- valid_in  input  1  data_in valid this cycle; no backpressure
- clr_in  input  1  synchronous clear of both counters only; state machine unaffected
- locked_out  output  1  high while state == LOCKED
- err_out  output  1  one-cycle pulse, registered, on each mismatch counted in LOCKED
- err_count_out  output  CNT_W  saturating mismatch count
- word_count_out  output  CNT_W  saturating count of valid words checked while LOCKED

Behaviour:
- Step function step(q), applied to the 16-bit word q:
  - bit15 = q14^q15
  - bits14..3 = q13..2
  - bit2 = q1^q15
  - bit1 = q0
  - bit0 = q15
  - Examples: step(0x0001)=0x0002, step(0x8000)=0x8005.
- Internal register pred holds the expected value of the next valid word.
- Only cycles with valid_in=1 advance anything; idle cycles hold all state.
- Reset: state=SEED, pred=0, match_cnt=0, miss_cnt=0, all outputs 0.
- SEED:
  - On valid: pred <= step(data_in), match_cnt <= 0, go to VERIFY.
  - A word of 0x0000 is ignored (all-zero lockup state); remain in SEED.
- VERIFY:
  - On valid with data_in==pred: pred <= step(pred), match_cnt+1.
  - When match_cnt reaches LOCK_COUNT, go to LOCKED on that same edge; locked_out is high the next cycle.
  - On valid with mismatch: reseed, i.e. pred <= step(data_in), match_cnt <= 0, stay in VERIFY.
  - A mismatching 0x0000 word instead returns to SEED.
- LOCKED:
  - Every valid word: pred <= step(pred). Prediction free-runs from its own state, so one corrupted word counts as exactly one error.
  - word_count_out increments on every valid word.
  - Match: miss_cnt <= 0.
  - Mismatch: err_out=1 the next cycle, err_count_out+1, miss_cnt+1.
  - Resync (only with AUTORESYNC compiled in): when miss_cnt reaches ERR_THRESH, go to SEED and deassert locked_out the next cycle. The triggering word still counts as an error.
- Counters:
  - Saturate at all-ones; no wrap.
  - clr_in zeroes both counters.
  - clr_in in the same cycle as an increment: clear wins, final value 0.
- Latency: error pulse and counter updates appear 1 cycle after the valid word; locked_out changes 1 cycle after the deciding word.
- Reset mid-operation returns to SEED with counters zeroed, regardless of valid_in.

Optional Feature:
- Macro: LFSR_CHK_AUTORESYNC_EN.
- Defined: ERR_THRESH consecutive mismatches in LOCKED return the block to SEED, as described in Behaviour.
- Undefined: LOCKED is left only via rst_in; mismatches are counted indefinitely and miss_cnt logic is removed.

Test Plan:
- Reset, then drive generator stream from seed 0x0001 (0x0002, 0x0004, ...) every cycle -> locked_out high after the 1st (seed) word + 4 matches; err_count_out stays 0; word_count_out matches the number of words fed after lock.
- Locked stream, flip bit 0 of one word -> single err_out pulse, err_count_out=1, lock retained, following correct words pass.
- AUTORESYNC_EN defined, ERR_THRESH=3, inject 3 consecutive garbage words -> err_count_out=3, locked_out drops; clean stream resumes -> relock after seed word + LOCK_COUNT matches.
- Stream containing 0x0000 words in SEED -> ignored, locked_out stays 0; a stream starting at 0x8000 predicts 0x8005 next and locks.
- Toggle valid_in with random gaps -> result identical to the gapless run; clr_in held high together with a mismatch -> counters read 0.
- Force error counter near saturation (CNT_W=4, 20 mismatches, AUTORESYNC undefined) -> err_count_out holds 0xF; assert rst_in mid-stream -> all outputs 0, state SEED.

Source files
------------

// File: rtl/lfsr_16_checker.sv
// -----------------------------------------------------------------------------
// lfsr_16_checker
//
// Receive-side checker for the 16-bit Galois LFSR pattern generator. Each
// valid cycle carries one full generator state word. The checker seeds its
// predictor from the stream. It verifies LOCK_COUNT consecutive predictions
// before declaring lock. While locked it flags and counts every mismatching
// word.
//
// Build option:
//   LFSR_CHK_AUTORESYNC_EN - when defined, ERR_THRESH consecutive mismatches
//                            while locked send the checker back to seeding.
//                            When undefined, lock is left only through rst_in.
//
// Parameters:
//   LOCK_COUNT - consecutive correct predictions needed to lock (1..255)
//   ERR_THRESH - consecutive locked mismatches forcing resync (1..255)
//   CNT_W      - width of both saturating counters
//
// Ports:
//   clk_in         in   1      system clock, rising edge
//   rst_in         in   1      synchronous active-high reset
//   data_in        in   16     received generator state word
//   valid_in       in   1      data_in valid this cycle
//   clr_in         in   1      synchronous clear of both counters
//   locked_out     out  1      high while locked
//   err_out        out  1      registered one-cycle pulse per counted mismatch
//   err_count_out  out  CNT_W  saturating mismatch count
//   word_count_out out  CNT_W  saturating count of words checked while locked
// -----------------------------------------------------------------------------
module lfsr_16_checker #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned ERR_THRESH = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [15:0]      data_in,
    input  logic             valid_in,
    input  logic             clr_in,
    output logic             locked_out,
    output logic             err_out,
    output logic [CNT_W-1:0] err_count_out,
    output logic [CNT_W-1:0] word_count_out
);

    // Reject illegal configurations at elaboration.
    if (LOCK_COUNT < 1 || LOCK_COUNT > 255) begin : g_bad_lock_count
        $error("lfsr_16_checker: LOCK_COUNT must be in 1..255");
    end
    if (ERR_THRESH < 1 || ERR_THRESH > 255) begin : g_bad_err_thresh
        $error("lfsr_16_checker: ERR_THRESH must be in 1..255");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("lfsr_16_checker: CNT_W must be at least 1");
    end

    localparam logic [7:0] LockTarget = 8'(LOCK_COUNT);

    typedef enum logic [1:0] {
        StSeed,
        StVerify,
        StLocked
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      pred_q, pred_d;
    logic [7:0]       match_cnt_q, match_cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic             match;
    logic             err_inc;
    logic             word_inc;

`ifdef LFSR_CHK_AUTORESYNC_EN
    localparam logic [7:0] ThreshTarget = 8'(ERR_THRESH);

    // Consecutive mismatches seen while locked.
    logic [7:0] miss_cnt_q, miss_cnt_d;
`endif

    // One generator step: shift left, and when bit 15 falls out, fold it back
    // into taps 15, 2 and 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {q[15] ^ q[14], q[13:2], q[15] ^ q[1], q[0], q[15]};
    endfunction

    assign match = (data_in == pred_q);

    // -------------------------------------------------------------------------
    // Next-state logic for the predictor and lock state machine
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pred_d      = pred_q;
        match_cnt_d = match_cnt_q;
        err_d       = 1'b0;
        err_inc     = 1'b0;
        word_inc    = 1'b0;
`ifdef LFSR_CHK_AUTORESYNC_EN
        miss_cnt_d  = miss_cnt_q;
`endif

        if (valid_in) begin
            unique case (state_q)
                StSeed: begin
                    // An all-zero word is the generator lockup state and can
                    // never seed a useful prediction.
                    if (data_in != 16'h0000) begin
                        pred_d      = lfsr_step(data_in);
                        match_cnt_d = 8'd0;
                        state_d     = StVerify;
                    end
                end

                StVerify: begin
                    if (match) begin
                        pred_d      = lfsr_step(pred_q);
                        match_cnt_d = match_cnt_q + 8'd1;
                        if (match_cnt_d == LockTarget) begin
                            state_d = StLocked;
                        end
                    end else if (data_in == 16'h0000) begin
                        match_cnt_d = 8'd0;
                        state_d     = StSeed;
                    end else begin
                        // Reseed from the word just received.
                        pred_d      = lfsr_step(data_in);
                        match_cnt_d = 8'd0;
                    end
                end

                StLocked: begin
                    // Free-run from our own prediction so a single corrupted
                    // word costs exactly one error.
                    pred_d   = lfsr_step(pred_q);
                    word_inc = 1'b1;
                    if (!match) begin
                        err_d   = 1'b1;
                        err_inc = 1'b1;
                    end
`ifdef LFSR_CHK_AUTORESYNC_EN
                    if (match) begin
                        miss_cnt_d = 8'd0;
                    end else begin
                        miss_cnt_d = miss_cnt_q + 8'd1;
                        if (miss_cnt_d == ThreshTarget) begin
                            miss_cnt_d = 8'd0;
                            state_d    = StSeed;
                        end
                    end
`endif
                end

                default: begin
                    state_d = StSeed;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Saturating counters; a clear in the same cycle as an increment wins.
    // -------------------------------------------------------------------------
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_in) begin
            err_cnt_d = '0;
        end else if (err_inc && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        word_cnt_d = word_cnt_q;
        if (clr_in) begin
            word_cnt_d = '0;
        end else if (word_inc && (word_cnt_q != '1)) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= StSeed;
            pred_q      <= 16'h0000;
            match_cnt_q <= 8'd0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            match_cnt_q <= match_cnt_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

`ifdef LFSR_CHK_AUTORESYNC_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            miss_cnt_q <= 8'd0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign locked_out     = (state_q == StLocked);
    assign err_out        = err_q;
    assign err_count_out  = err_cnt_q;
    assign word_count_out = word_cnt_q;

endmodule
